// File: rtl/flag_period_meter.sv
// Measures period and high time of a sys_clk-synchronous flag, and declares lock
// once EXP_PERIOD has been seen on LOCK_N consecutive periods.
module flag_period_meter #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 5,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX     = '1;
  localparam logic [CNT_W-1:0] C_EXP     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       C_LOCK_N  = 4'(LOCK_N);

  state_t           r_state;
  logic             r_sig_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [3:0]       r_matchcnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_timeout;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_p1;
  logic [3:0]       w_match_next;

  assign w_rise       = sig_in & ~r_sig_d;
  assign w_cnt_p1     = r_cnt + C_ONE;
  assign w_match_next = (r_matchcnt >= C_LOCK_N) ? C_LOCK_N : r_matchcnt + 4'd1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_sig_d      <= 1'b0;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_matchcnt   <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_sig_d      <= sig_in;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_hcnt  <= C_ONE;
            r_state <= MEAS;
          end
        end
        MEAS: begin
          // A rise on the timeout cycle is still a measurement, so it is tested first.
          if (w_rise) begin
            r_period     <= w_cnt_p1;
            r_high_time  <= (r_hcnt <= w_cnt_p1) ? r_hcnt : w_cnt_p1;
            r_meas_valid <= 1'b1;
            if (w_cnt_p1 == C_EXP) begin
              r_matchcnt <= w_match_next;
              r_locked   <= (w_match_next == C_LOCK_N);
            end else begin
              r_matchcnt <= '0;
              r_locked   <= 1'b0;
            end
            r_cnt  <= '0;
            r_hcnt <= C_ONE;
          end else if (r_cnt == C_TO_LAST) begin
            r_timeout  <= 1'b1;
            r_locked   <= 1'b0;
            r_matchcnt <= '0;
            r_state    <= IDLE;
          end else begin
            if (r_cnt != C_MAX) r_cnt <= w_cnt_p1;
            if (sig_in && (r_hcnt != C_MAX)) r_hcnt <= r_hcnt + C_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule

// File: doc/flag_period_meter.md
Name: flag_period_meter

Overview:
- Sits on the consumer side of a clock-divider flag output (e.g. divide-by-five `clk_flag`).
- Measures the period and high time, in `sys_clk` cycles, of a single-bit pulse/clock input that is synchronous to `sys_clk`.
- Declares lock once the measured period matches an expected division ratio for enough consecutive periods.
- Used as an on-chip checker and bring-up monitor for divider blocks.

Parameters:
- CNT_W, 16: width of the period/high-time counters and outputs.
- EXP_PERIOD, 5: expected period in `sys_clk` cycles, used for the lock compare.
- LOCK_N, 4: consecutive matching periods required to assert lock (1..15).
- TIMEOUT, 1000: cycles without a rising edge before a timeout is declared (< 2^CNT_W).

Ports:
- sys_clk, in, 1: system clock; all logic on its rising edge.
- sys_rst, in, 1: synchronous, active-high reset.
- sig_in, in, 1: monitored flag/clock, synchronous to `sys_clk`.
- period, out, CNT_W: last measured period (rise to rise), in cycles.
- high_time, out, CNT_W: last measured high time, in cycles.
- meas_valid, out, 1: one-cycle pulse when `period` and `high_time` update.
- locked, out, 1: expected period confirmed.
- timeout, out, 1: one-cycle pulse when no edge is seen for TIMEOUT cycles.

Behaviour:
- Reset values (`sys_rst`=1 at a clock edge): all outputs 0, state IDLE, sig_d=0, counters 0, match count 0.
- Edge detect: sig_d is `sig_in` registered; rise = `sig_in` & ~sig_d. A `sig_in` high during the first cycle after reset counts as a rise.
- States:
  - IDLE: wait for rise. On rise: cnt<=0, hcnt<=1, go to MEAS. No measurement output is produced on the first edge.
  - MEAS: cnt increments each cycle; hcnt increments each cycle `sig_in`=1.
- Rise in MEAS:
  - period<=cnt+1.
  - high_time<=hcnt if hcnt<=cnt+1, else cnt+1. hcnt excludes the current rise cycle.
  - meas_valid<=1 for that cycle's register update, so outputs are visible the cycle after the rise.
  - Then cnt<=0 and hcnt<=1.
- Example: pulses every 5 cycles give period=5. A 1-cycle-wide pulse gives high_time=1.
- Lock:
  - On each measurement, if cnt+1==EXP_PERIOD, matchcnt increments, saturating at LOCK_N.
  - When matchcnt reaches LOCK_N, locked<=1 in the same update as meas_valid.
  - A mismatching measurement clears matchcnt and locked in the same update.
- Timeout:
  - In MEAS, if cnt==TIMEOUT-1 and no rise this cycle: timeout pulses for 1 cycle, locked<=0, matchcnt<=0, state<=IDLE.
  - period and high_time hold their last values; meas_valid stays 0.
  - A rise in the same cycle as the timeout condition wins: it is a normal measurement, not a timeout.
- Saturation: cnt and hcnt never wrap; the timeout guarantees cnt < 2^CNT_W - 1.
- `sig_in` constant high: no rise, so the timeout fires. After that, IDLE waits for a true rise because sig_d=1.
- Reset mid-measurement: everything returns to reset values on that edge. The next rise after release restarts from IDLE.
- Outputs are all registered; no combinational path from `sig_in` to any output.

Test Plan:
- 1-cycle pulse every 5 cycles after reset release at 20 ns (20 ns clock):
  - first meas_valid one cycle after the second rise, with period=5, high_time=1;
  - locked=1 at the 4th meas_valid.
- 50%-ish divide-by-5 clock (high 3, low 2):
  - each meas_valid gives period=5, high_time=3;
  - locked asserts after 4 measurements.
- Locked stream with one gap making a single period of 7:
  - that meas_valid gives period=7 and locked drops the same cycle;
  - relock after 4 further period=5 measurements.
- Stop pulses with TIMEOUT=20:
  - timeout pulses exactly 20 cycles after the last rise, and locked=0;
  - period and high_time keep their last values;
  - the next two rises produce a meas_valid only on the second.
- Assert `sys_rst` for 1 cycle mid-period while locked:
  - all outputs 0 the next cycle;
  - first meas_valid only after two rises post-reset.
- `sig_in` held high from reset:
  - timeout fires at cycle TIMEOUT after the initial rise;
  - no meas_valid until a low-then-high transition occurs.
